// File: rtl/universal_register_pkg.sv
// Shared operation encodings for the universal register. Sequencer and ALU
// control logic import this package so every block agrees on Op values.
package universal_register_pkg;

  localparam int OpWidth = 3;

  localparam logic [OpWidth-1:0] OP_HOLD = 3'b000;
  localparam logic [OpWidth-1:0] OP_LOAD = 3'b001;
  localparam logic [OpWidth-1:0] OP_INC  = 3'b010;
  localparam logic [OpWidth-1:0] OP_DEC  = 3'b011;
  localparam logic [OpWidth-1:0] OP_SHL  = 3'b100;
  localparam logic [OpWidth-1:0] OP_SHR  = 3'b101;
  localparam logic [OpWidth-1:0] OP_ROL  = 3'b110;
  localparam logic [OpWidth-1:0] OP_ROR  = 3'b111;

endpackage

// File: rtl/universal_register.sv
// Multi-mode register: load, hold, up/down count (wrap or saturate),
// shift and rotate both ways, with registered Carry and Zero flags.
// All state changes on the falling edge of Clk; every output is a flop.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int                   DataWidth  = 8,
  parameter logic [DataWidth-1:0] ResetValue = '0,
  parameter bit                   Saturate   = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [OpWidth-1:0]   Op,
  input  logic                 SIn,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic                 Carry,
  output logic                 Zero
);

  localparam logic [DataWidth-1:0] AllOnes = '1;
  localparam logic [DataWidth-1:0] AllZero = '0;

  logic [DataWidth-1:0] r_dout;
  logic                 r_carry;
  logic                 r_zero;

  logic [DataWidth-1:0] w_next_dout;
  logic                 w_next_carry;
  logic                 w_msb;
  logic                 w_lsb;

  assign w_msb = r_dout[DataWidth-1];
  assign w_lsb = r_dout[0];

  // Next word and next carry for the selected operation; En low means hold.
  always_comb begin
    w_next_dout  = r_dout;
    w_next_carry = r_carry;
    if (En) begin
      case (Op)
        OP_HOLD: begin
          w_next_dout  = r_dout;
          w_next_carry = r_carry;
        end
        OP_LOAD: begin
          w_next_dout  = DIn;
          w_next_carry = 1'b0;
        end
        OP_INC: begin
          w_next_carry = (r_dout == AllOnes);
          // Saturating mode clamps at all-ones but still flags the overflow.
          if (Saturate && (r_dout == AllOnes)) w_next_dout = AllOnes;
          else                                 w_next_dout = r_dout + 1'b1;
        end
        OP_DEC: begin
          w_next_carry = (r_dout == AllZero);
          if (Saturate && (r_dout == AllZero)) w_next_dout = AllZero;
          else                                 w_next_dout = r_dout - 1'b1;
        end
        OP_SHL: begin
          w_next_dout  = {r_dout[DataWidth-2:0], SIn};
          w_next_carry = w_msb;
        end
        OP_SHR: begin
          w_next_dout  = {SIn, r_dout[DataWidth-1:1]};
          w_next_carry = w_lsb;
        end
        OP_ROL: begin
          w_next_dout  = {r_dout[DataWidth-2:0], w_msb};
          w_next_carry = w_msb;
        end
        OP_ROR: begin
          w_next_dout  = {w_lsb, r_dout[DataWidth-1:1]};
          w_next_carry = w_lsb;
        end
        default: begin
          w_next_dout  = r_dout;
          w_next_carry = r_carry;
        end
      endcase
    end
  end

  // State update on the falling edge; Zero is derived from the new word so
  // it always matches DOut. Reset wins over En and Op.
  always_ff @(negedge Clk) begin
    if (Reset) begin
      r_dout  <= ResetValue;
      r_carry <= 1'b0;
      r_zero  <= (ResetValue == AllZero);
    end else begin
      r_dout  <= w_next_dout;
      r_carry <= w_next_carry;
      r_zero  <= (w_next_dout == AllZero);
    end
  end

`ifdef SIMULATE
  // Simulation trace of every accepted LOAD.
  always @(negedge Clk) begin
    if (!Reset && En && (Op == OP_LOAD))
      $display("%0t universal_register LOAD %b 0x%h", $time, DIn, DIn);
  end
`endif

  assign DOut  = r_dout;
  assign Carry = r_carry;
  assign Zero  = r_zero;

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: a wrapping and a saturating instance share
// the same stimulus and are compared against an arithmetic reference model.
module tb_universal_register;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Op;
  logic       SIn;
  logic [7:0] DIn;
  logic [7:0] dout_w, dout_s;
  logic       carry_w, carry_s, zero_w, zero_s;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = wrapping instance, index 1 = saturating instance.
  int m_val [2];
  int m_car [2];

  universal_register #(.DataWidth(8), .ResetValue(8'h5A), .Saturate(1'b0)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .En(En), .Op(Op), .SIn(SIn), .DIn(DIn),
    .DOut(dout_w), .Carry(carry_w), .Zero(zero_w)
  );

  universal_register #(.DataWidth(8), .ResetValue(8'h5A), .Saturate(1'b1)) dut_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Op(Op), .SIn(SIn), .DIn(DIn),
    .DOut(dout_s), .Carry(carry_s), .Zero(zero_s)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the operation rules with plain integers.
  task automatic model_update(input int idx, input bit rst, input bit en,
                              input int op, input int din, input int sin);
    int v;
    int c;
    v = m_val[idx];
    c = m_car[idx];
    if (rst) begin
      v = 'h5A;
      c = 0;
    end else if (en) begin
      case (op)
        1: begin v = din; c = 0; end
        2: begin
          if (v == 255) begin c = 1; v = (idx == 1) ? 255 : 0; end
          else begin c = 0; v = v + 1; end
        end
        3: begin
          if (v == 0) begin c = 1; v = (idx == 1) ? 0 : 255; end
          else begin c = 0; v = v - 1; end
        end
        4: begin c = v / 128; v = (v * 2) % 256 + sin; end
        5: begin c = v % 2;   v = v / 2 + sin * 128; end
        6: begin c = v / 128; v = (v * 2) % 256 + c; end
        7: begin c = v % 2;   v = v / 2 + c * 128; end
        default: ;
      endcase
    end
    m_val[idx] = v;
    m_car[idx] = c;
  endtask

  task automatic check_all(input string tag);
    check({tag, " dout_wrap"},  int'(dout_w),  m_val[0]);
    check({tag, " carry_wrap"}, int'(carry_w), m_car[0]);
    check({tag, " zero_wrap"},  int'(zero_w),  (m_val[0] == 0) ? 1 : 0);
    check({tag, " dout_sat"},   int'(dout_s),  m_val[1]);
    check({tag, " carry_sat"},  int'(carry_s), m_car[1]);
    check({tag, " zero_sat"},   int'(zero_s),  (m_val[1] == 0) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, let the falling edge act, check on the rising edge.
  task automatic do_op(input bit rst, input bit en, input int op, input int din,
                       input int sin, input string tag);
    Reset = rst;
    En    = en;
    Op    = op[2:0];
    DIn   = din[7:0];
    SIn   = sin[0];
    @(negedge Clk);
    model_update(0, rst, en, op, din, sin);
    model_update(1, rst, en, op, din, sin);
    @(posedge Clk);
    $display("%0t %s rst=%0d en=%0d op=%0d din=%02h sin=%0d -> wrap %02h/%0d/%0d sat %02h/%0d/%0d",
             $time, tag, rst, en, op, din, sin, dout_w, carry_w, zero_w, dout_s, carry_s, zero_s);
    check_all(tag);
  endtask

  initial begin
    int op, din, sin, en, rst;
    m_val[0] = 0; m_val[1] = 0; m_car[0] = 0; m_car[1] = 0;
    Reset = 1'b1; En = 1'b0; Op = 3'd0; SIn = 1'b0; DIn = 8'h00;

    // Reset and hold.
    do_op(1, 0, 0, 0, 0, "reset");
    check("reset literal", int'(dout_w), 'h5A);
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, 0, 0, "hold");

    // Reset interrupting an INC run.
    do_op(0, 1, 2, 0, 0, "inc");
    do_op(0, 1, 2, 0, 0, "inc");
    do_op(1, 1, 2, 0, 0, "reset_mid_inc");
    check("reset_mid_inc literal", int'(dout_s), 'h5A);
    do_op(0, 1, 2, 0, 0, "inc_after_reset");
    check("inc_after_reset literal", int'(dout_w), 'h5B);

    // Increment across the top boundary.
    do_op(0, 1, 1, 'hFE, 0, "load_fe");
    do_op(0, 1, 2, 0, 0, "inc_to_ff");
    do_op(0, 1, 2, 0, 0, "inc_past_ff");
    check("wrap inc literal", int'(dout_w), 0);
    check("sat inc literal",  int'(dout_s), 'hFF);
    check("sat inc carry literal", int'(carry_s), 1);

    // Decrement across the bottom boundary.
    do_op(0, 1, 1, 'h01, 0, "load_01");
    do_op(0, 1, 3, 0, 0, "dec_to_00");
    do_op(0, 1, 3, 0, 0, "dec_past_00");
    check("wrap dec literal", int'(dout_w), 'hFF);
    check("sat dec literal",  int'(dout_s), 0);

    // Shifts and rotates.
    do_op(0, 1, 1, 'h81, 0, "load_81");
    do_op(0, 1, 4, 0, 1, "shl_sin1");
    check("shl literal", int'(dout_w), 'h03);
    do_op(0, 1, 5, 0, 0, "shr_sin0");
    check("shr literal", int'(dout_w), 'h01);
    do_op(0, 1, 1, 'h81, 0, "load_81");
    do_op(0, 1, 7, 0, 1, "ror");
    check("ror literal", int'(dout_w), 'hC0);
    do_op(0, 1, 6, 0, 0, "rol");
    check("rol literal", int'(dout_w), 'h81);

    // Enable gating.
    do_op(0, 0, 1, 'h33, 1, "en_low_load");
    do_op(0, 0, 1, 'h33, 1, "en_low_load");
    do_op(0, 1, 1, 'h33, 0, "en_high_load");
    check("en_high_load literal", int'(dout_w), 'h33);

    // Reset held with active INC.
    for (int i = 0; i < 3; i++) do_op(1, 1, 2, 0, 0, "reset_hold_inc");

    // Randomized mix with occasional reset and enable drop.
    for (int i = 0; i < 500; i++) begin
      op  = int'($urandom_range(0, 7));
      din = int'($urandom_range(0, 255));
      sin = int'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
      // Bias toward the counting boundaries now and then.
      if (op == 1 && $urandom_range(0, 3) == 0) din = ($urandom_range(0, 1) != 0) ? 255 : 0;
      do_op(rst[0], en[0], op, din, sin, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
